arc4_sched: RTL and testbench

- Top-level sequencer for the ARC4 datapath.
- On one start request it runs init (fill S[i]=i), then KSA (key schedule), then PRGA (keystream and decrypt) in order.
- Each phase is driven through the phase block's en/rdy handshake.
- Owns the single S-memory port and grants it to exactly one phase block at a time.

---
 rtl/arc4_pkg.sv | 35 +++
 rtl/arc4_smem_mux.sv | 47 ++++
 rtl/arc4_sched.sv | 120 ++++++++++++
 tb/tb_arc4_sched.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 scheduler and its S-memory grant mux.
package arc4_pkg;

  localparam int ARC4_ADDR_W = 8;
  localparam int ARC4_KEY_W  = 24;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT_GO  = 3'd1,
    ST_INIT_RUN = 3'd2,
    ST_KSA_GO   = 3'd3,
    ST_KSA_RUN  = 3'd4,
    ST_PRGA_GO  = 3'd5,
    ST_PRGA_RUN = 3'd6
  } sched_state_t;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_INIT = 2'd1,
    PH_KSA  = 2'd2,
    PH_PRGA = 2'd3
  } phase_t;

  // Both the GO and RUN state of a phase report that phase, so the memory
  // grant is already in place when the phase block sees its en pulse.
  function automatic phase_t state_phase(input sched_state_t s);
    case (s)
      ST_INIT_GO, ST_INIT_RUN: return PH_INIT;
      ST_KSA_GO,  ST_KSA_RUN:  return PH_KSA;
      ST_PRGA_GO, ST_PRGA_RUN: return PH_PRGA;
      default:                 return PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/arc4_smem_mux.sv
// Combinational 3:1 S-memory write-port grant; only the selected phase block
// reaches the memory, and idle drives an all-zero, write-disabled port.
module arc4_smem_mux
  import arc4_pkg::*;
#(
  parameter int ADDR_W = ARC4_ADDR_W
) (
  input  phase_t             i_sel,
  input  logic [ADDR_W-1:0]  i_init_addr,
  input  logic [7:0]         i_init_wrdata,
  input  logic               i_init_wren,
  input  logic [ADDR_W-1:0]  i_ksa_addr,
  input  logic [7:0]         i_ksa_wrdata,
  input  logic               i_ksa_wren,
  input  logic [ADDR_W-1:0]  i_prga_addr,
  input  logic [7:0]         i_prga_wrdata,
  input  logic               i_prga_wren,
  output logic [ADDR_W-1:0]  o_addr,
  output logic [7:0]         o_wrdata,
  output logic               o_wren
);

  always_comb begin
    o_addr   = '0;
    o_wrdata = '0;
    o_wren   = 1'b0;
    case (i_sel)
      PH_INIT: begin
        o_addr   = i_init_addr;
        o_wrdata = i_init_wrdata;
        o_wren   = i_init_wren;
      end
      PH_KSA: begin
        o_addr   = i_ksa_addr;
        o_wrdata = i_ksa_wrdata;
        o_wren   = i_ksa_wren;
      end
      PH_PRGA: begin
        o_addr   = i_prga_addr;
        o_wrdata = i_prga_wrdata;
        o_wren   = i_prga_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/arc4_sched.sv
// ARC4 top sequencer: init -> KSA -> PRGA per start request, owning the S-memory port.
// Optional build macro ARC4_SCHED_PERF_EN adds the cyc_cnt busy-cycle counter.
module arc4_sched
  import arc4_pkg::*;
#(
  parameter int KEY_W  = ARC4_KEY_W,
  parameter int ADDR_W = ARC4_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic               rdy,
  input  logic [KEY_W-1:0]   key,
  output logic [KEY_W-1:0]   key_q,
  output logic               init_en,
  output logic               ksa_en,
  output logic               prga_en,
  input  logic               init_rdy,
  input  logic               ksa_rdy,
  input  logic               prga_rdy,
  input  logic [ADDR_W-1:0]  init_addr,
  input  logic [ADDR_W-1:0]  ksa_addr,
  input  logic [ADDR_W-1:0]  prga_addr,
  input  logic [7:0]         init_wrdata,
  input  logic [7:0]         ksa_wrdata,
  input  logic [7:0]         prga_wrdata,
  input  logic               init_wren,
  input  logic               ksa_wren,
  input  logic               prga_wren,
  output logic [ADDR_W-1:0]  s_addr,
  output logic [7:0]         s_wrdata,
  output logic               s_wren,
  output logic [1:0]         phase,
`ifdef ARC4_SCHED_PERF_EN
  output logic [31:0]        cyc_cnt,
`endif
  output logic [2:0]         o_dbg_state
);

  // Handshake: a transfer occurs on a rising edge where valid (en / x_en) and
  // ready (rdy / x_rdy) are both 1; valid while not ready is dropped, never queued.

  sched_state_t       r_state;
  sched_state_t       w_next;
  logic [KEY_W-1:0]   r_key_q;
  phase_t             w_phase;
  logic               w_accept;

  assign rdy         = (r_state == ST_IDLE);
  assign w_accept    = en && rdy;
  assign w_phase     = state_phase(r_state);
  assign phase       = w_phase;
  assign key_q       = r_key_q;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst)           r_key_q <= '0;
    else if (w_accept) r_key_q <= key;
  end

  // x_en mirrors x_rdy in GO, so the pulse lands exactly on the accepting edge.
  always_comb begin
    w_next  = r_state;
    init_en = 1'b0;
    ksa_en  = 1'b0;
    prga_en = 1'b0;
    case (r_state)
      ST_IDLE:     if (en) w_next = ST_INIT_GO;
      ST_INIT_GO: begin
        init_en = init_rdy;
        if (init_rdy) w_next = ST_INIT_RUN;
      end
      ST_INIT_RUN: if (init_rdy) w_next = ST_KSA_GO;
      ST_KSA_GO: begin
        ksa_en = ksa_rdy;
        if (ksa_rdy) w_next = ST_KSA_RUN;
      end
      ST_KSA_RUN:  if (ksa_rdy) w_next = ST_PRGA_GO;
      ST_PRGA_GO: begin
        prga_en = prga_rdy;
        if (prga_rdy) w_next = ST_PRGA_RUN;
      end
      ST_PRGA_RUN: if (prga_rdy) w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  arc4_smem_mux #(.ADDR_W(ADDR_W)) u_smem_mux (
    .i_sel         (w_phase),
    .i_init_addr   (init_addr),
    .i_init_wrdata (init_wrdata),
    .i_init_wren   (init_wren),
    .i_ksa_addr    (ksa_addr),
    .i_ksa_wrdata  (ksa_wrdata),
    .i_ksa_wren    (ksa_wren),
    .i_prga_addr   (prga_addr),
    .i_prga_wrdata (prga_wrdata),
    .i_prga_wren   (prga_wren),
    .o_addr        (s_addr),
    .o_wrdata      (s_wrdata),
    .o_wren        (s_wren)
  );

`ifdef ARC4_SCHED_PERF_EN
  logic [31:0] r_cyc_cnt;

  always_ff @(posedge clk) begin
    if (rst || w_accept)              r_cyc_cnt <= '0;
    else if (!rdy && (r_cyc_cnt != '1)) r_cyc_cnt <= r_cyc_cnt + 32'd1;
  end

  assign cyc_cnt = r_cyc_cnt;
`endif

endmodule

// File: tb/tb_arc4_sched.sv
// Bench for arc4_sched: phase-block models, grant vector table, directed corner
// sequences and randomized transactions against a latency/ordering scoreboard.
module tb_arc4_sched;

  localparam int KEY_W  = 24;
  localparam int ADDR_W = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              en  = 1'b1;
  logic [KEY_W-1:0]  key = 24'h777777;
  logic              rdy;
  logic [KEY_W-1:0]  key_q;
  logic              init_en, ksa_en, prga_en;
  logic              init_rdy, ksa_rdy, prga_rdy;
  logic [ADDR_W-1:0] init_addr = '0, ksa_addr = '0, prga_addr = '0;
  logic [7:0]        init_wrdata = '0, ksa_wrdata = '0, prga_wrdata = '0;
  logic              init_wren = 1'b0, ksa_wren = 1'b0, prga_wren = 1'b0;
  logic [ADDR_W-1:0] s_addr;
  logic [7:0]        s_wrdata;
  logic              s_wren;
  logic [1:0]        phase;
  logic [2:0]        dbg_state;
`ifdef ARC4_SCHED_PERF_EN
  logic [31:0]       cyc_cnt;
`endif

  arc4_sched #(.KEY_W(KEY_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .key_q(key_q),
    .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
    .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
    .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata), .prga_wrdata(prga_wrdata),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .phase(phase),
`ifdef ARC4_SCHED_PERF_EN
    .cyc_cnt(cyc_cnt),
`endif
    .o_dbg_state(dbg_state)
  );

  // Phase-block models: idle blocks are ready; after accepting x_en a block
  // holds rdy low for blk_len cycles. hold[] forces a block not-ready.
  logic [2:0] mdl_rdy = 3'b111;
  logic [2:0] hold    = 3'b000;
  int blk_len[3] = '{0, 0, 0};
  int acc_cnt[3] = '{0, 0, 0};
  int rst_ev = 0;
  int seen_acc[3] = '{0, 0, 0};
  int seen_rst = 0;
  int bcnt[3] = '{0, 0, 0};

  assign init_rdy = mdl_rdy[0] & ~hold[0];
  assign ksa_rdy  = mdl_rdy[1] & ~hold[1];
  assign prga_rdy = mdl_rdy[2] & ~hold[2];

  always @(posedge clk) begin
    if (rst) rst_ev <= rst_ev + 1;
    else begin
      if (init_en && init_rdy) acc_cnt[0] <= acc_cnt[0] + 1;
      if (ksa_en  && ksa_rdy)  acc_cnt[1] <= acc_cnt[1] + 1;
      if (prga_en && prga_rdy) acc_cnt[2] <= acc_cnt[2] + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_ev != seen_rst) begin
      seen_rst = rst_ev;
      for (int k = 0; k < 3; k++) begin
        bcnt[k] = 0; mdl_rdy[k] = 1'b1; seen_acc[k] = acc_cnt[k];
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (acc_cnt[k] != seen_acc[k]) begin
          seen_acc[k] = acc_cnt[k];
          bcnt[k]     = blk_len[k];
          mdl_rdy[k]  = (blk_len[k] == 0);
        end else if (bcnt[k] > 0) begin
          bcnt[k]    = bcnt[k] - 1;
          mdl_rdy[k] = (bcnt[k] == 0);
        end
      end
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory-port driver and grant reference
  logic [7:0] m_addr[3];
  logic [7:0] m_data[3];
  logic [2:0] m_we;

  task automatic drive_mem(input logic [2:0] we, input logic [7:0] a0, a1, a2, d0, d1, d2);
    m_we = we;
    m_addr[0] = a0; m_addr[1] = a1; m_addr[2] = a2;
    m_data[0] = d0; m_data[1] = d1; m_data[2] = d2;
    init_wren = we[0]; ksa_wren = we[1]; prga_wren = we[2];
    init_addr = a0; ksa_addr = a1; prga_addr = a2;
    init_wrdata = d0; ksa_wrdata = d1; prga_wrdata = d2;
  endtask

  function automatic logic [16:0] grant_model(input int ph);
    if (ph == 0) return 17'h0;
    return {m_addr[ph-1], m_data[ph-1], m_we[ph-1]};
  endfunction

  typedef struct {
    logic [2:0]  we;
    logic [7:0]  a0, a1, a2, d0, d1, d2;
    logic [16:0] exp;
  } gvec_t;
  gvec_t tbl[6];

  // One full start..done transaction with latency, pulse and phase-order checks.
  task automatic run_txn(input logic [KEY_W-1:0] k, input int l0, l1, l2, input bit noise);
    int pulses[3];
    int order_code, ph_code, cyc;
    logic [1:0] last_ph;
    logic [31:0] lat;
    bit done, noise_ok;
    pulses = '{0, 0, 0};
    order_code = 0; ph_code = 0; cyc = 0; last_ph = 2'd0; done = 1'b0;
    blk_len[0] = l0; blk_len[1] = l1; blk_len[2] = l2;
    exp_q.push_back(32'(l0 + l1 + l2 + 7));
    @(negedge clk); en = 1'b1; key = k; #1;
    chk("txn_accept_rdy", 32'(rdy), 32'd1);
    for (int t = 0; t < 4000 && !done; t++) begin
      if (phase != last_ph) begin
        ph_code = ph_code * 4 + int'(phase);
        last_ph = phase;
      end
      if (t > 0 && rdy) done = 1'b1;
      else begin
        cyc++;
        if (init_en) begin pulses[0]++; order_code = order_code * 4 + 1; end
        if (ksa_en)  begin pulses[1]++; order_code = order_code * 4 + 2; end
        if (prga_en) begin pulses[2]++; order_code = order_code * 4 + 3; end
        noise_ok = (phase == 2'd1);
        @(negedge clk);
        en  = noise && noise_ok && ($urandom_range(0, 3) == 0);
        key = en ? 24'hFFFFFF : KEY_W'($urandom);
        #1;
      end
    end
    en = 1'b0;
    lat = exp_q.pop_front();
    chk("txn_done", 32'(done), 32'd1);
    chk("txn_latency", 32'(cyc), lat);
    chk("txn_init_pulses", 32'(pulses[0]), 32'd1);
    chk("txn_ksa_pulses", 32'(pulses[1]), 32'd1);
    chk("txn_prga_pulses", 32'(pulses[2]), 32'd1);
    chk("txn_pulse_order", 32'(order_code), 32'(((1 * 4) + 2) * 4 + 3));
    chk("txn_phase_order", 32'(ph_code), 32'((((1 * 4) + 2) * 4 + 3) * 4 + 0));
    chk("txn_key_q", 32'(key_q), 32'(k));
`ifdef ARC4_SCHED_PERF_EN
    chk("txn_cyc_cnt", cyc_cnt, lat - 32'd1);
`endif
  endtask

  task automatic wait_acc(input int idx, input int base, input string name);
    bit hit = 1'b0;
    for (int t = 0; t < 300 && !hit; t++) begin
      if (acc_cnt[idx] != base) hit = 1'b1;
      else begin @(negedge clk); #1; end
    end
    chk(name, 32'(hit), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit hit = 1'b0;
    for (int t = 0; t < 3000 && !hit; t++) begin
      if (rdy) hit = 1'b1;
      else begin @(negedge clk); #1; end
    end
    chk(name, 32'(hit), 32'd1);
  endtask

  initial begin
    int base[3];
    logic [16:0] got;
    logic [KEY_W-1:0] rk;
    bit found;

    tbl[0] = '{3'b101, 8'h11, 8'hA5, 8'h22, 8'h33, 8'h44, 8'h55, {8'hA5, 8'h44, 1'b0}};
    tbl[1] = '{3'b010, 8'h11, 8'hA5, 8'h22, 8'h33, 8'h5A, 8'h55, {8'hA5, 8'h5A, 1'b1}};
    tbl[2] = '{3'b111, 8'hFE, 8'h00, 8'h01, 8'h02, 8'hFF, 8'h03, {8'h00, 8'hFF, 1'b1}};
    tbl[3] = '{3'b000, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h00, {8'hFF, 8'h01, 1'b0}};
    tbl[4] = '{3'b010, 8'hA5, 8'h3C, 8'hA5, 8'h66, 8'h77, 8'h88, {8'h3C, 8'h77, 1'b1}};
    tbl[5] = '{3'b011, 8'h80, 8'h7F, 8'h81, 8'hC0, 8'h3F, 8'hC1, {8'h7F, 8'h3F, 1'b1}};
    drive_mem(3'b000, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);

    // reset held two cycles with en=1: no accept, idle outputs
    @(negedge clk);
    @(negedge clk); #1;
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_en_pulses", 32'({init_en, ksa_en, prga_en}), 32'd0);
    chk("rst_s_wren", 32'(s_wren), 32'd0);
    chk("rst_s_addr", 32'({s_addr, s_wrdata}), 32'd0);
    chk("rst_key_q", 32'(key_q), 32'd0);
`ifdef ARC4_SCHED_PERF_EN
    chk("rst_cyc_cnt", cyc_cnt, 32'd0);
`endif
    @(negedge clk); rst = 1'b0; en = 1'b0; #1;
    @(negedge clk); #1;
    chk("rst_no_accept", 32'(phase), 32'd0);

    // full sequence with busy en pulses (key FFFFFF) during init
    run_txn(24'h00033C, 256, 768, 100, 1'b1);

    // grant isolation: table in KSA, random vectors in every phase and idle
    blk_len[0] = 40; blk_len[1] = 40; blk_len[2] = 40;
    for (int k = 0; k < 3; k++) base[k] = acc_cnt[k];
    @(negedge clk); en = 1'b1; key = 24'hABCDEF; #1;
    @(negedge clk); en = 1'b0; #1;
    for (int p = 1; p <= 3; p++) begin
      wait_acc(p - 1, base[p-1], "grant_reach_phase");
      chk("grant_phase", 32'(phase), 32'(p));
      if (p == 2) begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          drive_mem(tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].d0, tbl[i].d1, tbl[i].d2);
          #1;
          got = {s_addr, s_wrdata, s_wren};
          chk("grant_tbl", 32'(got), 32'(tbl[i].exp));
        end
      end
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        drive_mem(3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom), 8'($urandom), 8'($urandom));
        #1;
        got = {s_addr, s_wrdata, s_wren};
        chk("grant_rand", 32'(got), 32'(grant_model(p)));
      end
    end
    wait_idle("grant_finish");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_mem(3'b111, 8'($urandom), 8'($urandom), 8'($urandom),
                8'($urandom), 8'($urandom), 8'($urandom));
      #1;
      got = {s_addr, s_wrdata, s_wren};
      chk("grant_idle", 32'(got), 32'(grant_model(0)));
    end
    @(negedge clk); drive_mem(3'b000, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);

    // stalled start: ksa_rdy low at KSA_GO entry for 5 cycles
    hold[1] = 1'b1;
    blk_len[0] = 3; blk_len[1] = 5; blk_len[2] = 3;
    base[1] = acc_cnt[1];
    @(negedge clk); en = 1'b1; key = 24'h5A5A5A; #1;
    @(negedge clk); en = 1'b0; #1;
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      if (phase == 2'd2) found = 1'b1;
      else begin @(negedge clk); #1; end
    end
    chk("stall_reach_ksa", 32'(found), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_ksa_en_low", 32'(ksa_en), 32'd0);
      chk("stall_hold_phase", 32'(phase), 32'd2);
      @(negedge clk);
      if (i == 4) hold[1] = 1'b0;
      #1;
    end
    chk("stall_pulse", 32'(ksa_en), 32'd1);
    @(negedge clk); #1;
    chk("stall_pulse_end", 32'(ksa_en), 32'd0);
    chk("stall_run_phase", 32'(phase), 32'd2);
    chk("stall_single_accept", 32'(acc_cnt[1] - base[1]), 32'd1);
    wait_idle("stall_finish");
    chk("stall_key_q", 32'(key_q), 32'h5A5A5A);

    // mid-run reset during PRGA, then a normal restart
    blk_len[0] = 4; blk_len[1] = 4; blk_len[2] = 300;
    base[2] = acc_cnt[2];
    @(negedge clk); en = 1'b1; key = 24'h123456; #1;
    @(negedge clk); en = 1'b0; #1;
    wait_acc(2, base[2], "mrst_reach_prga");
    @(negedge clk); drive_mem(3'b100, 8'h0, 8'h0, 8'h77, 8'h0, 8'h0, 8'h99); #1;
    chk("mrst_pre_grant", 32'({s_addr, s_wrdata, s_wren}), 32'({8'h77, 8'h99, 1'b1}));
    @(negedge clk); rst = 1'b1; #1;
    @(negedge clk); rst = 1'b0; #1;
    chk("mrst_phase", 32'(phase), 32'd0);
    chk("mrst_rdy", 32'(rdy), 32'd1);
    chk("mrst_s_wren", 32'(s_wren), 32'd0);
    chk("mrst_key_q", 32'(key_q), 32'd0);
    @(negedge clk); drive_mem(3'b000, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    run_txn(24'h0F1E2D, 2, 3, 4, 1'b0);

    // randomized transactions, including zero-length phases
    for (int n = 0; n < 8; n++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) @(negedge clk);
      rk = KEY_W'($urandom);
      run_txn(rk, $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20), 1'b1);
    end
    run_txn(24'h000001, 0, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
